despachador_trabajos: RTL and testbench

//  Upstream job loader for sistema_area: accepts a byte stream (12 payload bytes + 1 target byte),

---
 rtl/despachador_trabajos.sv | 141 ++++++++++++++
 tb/tb_despachador_trabajos.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/despachador_trabajos.sv
// Job loader for sistema_area: collects payload+target bytes, runs one search, returns nonce/hash.
// Optional RUN-state watchdog enabled by defining DESPACHO_TIMEOUT_EN.
module despachador_trabajos #(
    parameter int PAYLOAD_BYTES  = 12,
    parameter int NONCE_W        = 32,
    parameter int HASH_W         = 24,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [7:0]                 in_byte,
    output logic                       in_ready,
    output logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic [7:0]                 target,
    output logic                       active,
    input  logic                       terminado,
    input  logic [NONCE_W-1:0]         nonceIn,
    input  logic [HASH_W-1:0]          hashIn,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [NONCE_W-1:0]         res_nonce,
    output logic [HASH_W-1:0]          res_hash,
    output logic                       res_timeout,
    output logic                       busy
);

    localparam int PW = 8 * PAYLOAD_BYTES;
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_RUN,
        S_RESULT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_payload;
    logic [7:0]      r_target;
    logic [NONCE_W-1:0] r_nonce;
    logic [HASH_W-1:0]  r_hash;
    logic            w_in_hs;
    logic            w_last_byte;
    logic            w_expire;

    // in_ready is masked by reset_n so no byte is offered during the reset cycle.
    assign in_ready    = reset_n && (r_state == S_COLLECT);
    assign w_in_hs     = in_valid && in_ready;
    assign w_last_byte = (r_cnt == CW'(PAYLOAD_BYTES));

    assign payload   = r_payload;
    assign target    = r_target;
    assign active    = (r_state == S_RUN);
    assign res_valid = (r_state == S_RESULT);
    assign res_nonce = r_nonce;
    assign res_hash  = r_hash;
    assign busy      = (r_state != S_COLLECT);

`ifdef DESPACHO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout;

    // Counter holds zero outside RUN, so every RUN entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (!reset_n || r_state != S_RUN) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    assign w_expire    = (r_state == S_RUN) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign res_timeout = r_timeout;
`else
    assign w_expire    = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_COLLECT: if (w_in_hs && w_last_byte)  w_next = S_RUN;
            S_RUN:     if (terminado || w_expire)   w_next = S_RESULT;
            S_RESULT:  if (res_ready)               w_next = S_COLLECT;
            default:                                w_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_payload <= '0;
            r_target  <= '0;
            r_nonce   <= '0;
            r_hash    <= '0;
`ifdef DESPACHO_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
            if (w_in_hs) begin
                if (w_last_byte) begin
                    r_target <= in_byte;
                    r_cnt    <= '0;
                end else begin
                    // Byte k lands in slot k counted from the MSB end; other slots keep old data.
                    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
                        if (r_cnt == CW'(k)) r_payload[PW-1-8*k -: 8] <= in_byte;
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (r_state == S_RUN) begin
                // terminado takes priority over a simultaneous watchdog expiry.
                if (terminado) begin
                    r_nonce <= nonceIn;
                    r_hash  <= hashIn;
`ifdef DESPACHO_TIMEOUT_EN
                    r_timeout <= 1'b0;
                end else if (w_expire) begin
                    r_nonce   <= '1;
                    r_hash    <= '0;
                    r_timeout <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_despachador_trabajos.sv
// Scoreboard bench for despachador_trabajos: stub drives terminado/nonce/hash, queue holds results.
module tb_despachador_trabajos;

    localparam int NW   = 32;
    localparam int HW   = 24;
    localparam int TCYC = 100;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic [95:0]   payload;
    logic [7:0]    target;
    logic          active;
    logic          terminado;
    logic [NW-1:0] nonceIn;
    logic [HW-1:0] hashIn;
    logic          res_valid;
    logic          res_ready;
    logic [NW-1:0] res_nonce;
    logic [HW-1:0] res_hash;
    logic          res_timeout;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NW+HW:0] sbq[$];

    always #5 clk = ~clk;

    despachador_trabajos #(
        .PAYLOAD_BYTES (12),
        .NONCE_W       (NW),
        .HASH_W        (HW),
        .TIMEOUT_CYCLES(TCYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .payload    (payload),
        .target     (target),
        .active     (active),
        .terminado  (terminado),
        .nonceIn    (nonceIn),
        .hashIn     (hashIn),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_nonce  (res_nonce),
        .res_hash   (res_hash),
        .res_timeout(res_timeout),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] pack(input logic [7:0] b[13]);
        logic [95:0] p = '0;
        for (int k = 0; k < 12; k++) p = {p[87:0], b[k]};
        return p;
    endfunction

    task automatic send_job(input logic [7:0] b[13], input int gap);
        for (int k = 0; k < 13; k++) begin
            int t = 0;
            in_byte  = b[k];
            in_valid = 1'b1;
            while (!in_ready && t < 50) begin
                tick();
                t++;
            end
            if (!in_ready) check("in_ready_wait", in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic finish_job(input logic [NW-1:0] n, input logic [HW-1:0] h);
        terminado = 1'b1;
        nonceIn   = n;
        hashIn    = h;
        sbq.push_back({1'b0, n, h});
        tick();
        terminado = 1'b0;
        nonceIn   = $urandom;
        hashIn    = HW'($urandom);
        check("active_drop", active, 1'b0);
        check("res_valid_rise", res_valid, 1'b1);
    endtask

    task automatic consume(input int hold, input logic try_byte, input logic [7:0] old_b0);
        logic [NW+HW:0] exp;
        int t = 0;
        for (int c = 0; c < hold; c++) begin
            res_ready = 1'b0;
            tick();
            check("res_valid_hold", res_valid, 1'b1);
            if (sbq.size() > 0) check("res_stable", {res_timeout, res_nonce, res_hash}, sbq[0]);
        end
        res_ready = 1'b1;
        while (!res_valid && t < 300) begin
            tick();
            t++;
        end
        if (!res_valid) check("res_valid_wait", res_valid, 1'b1);
        if (sbq.size() == 0) begin
            check("sb_empty", 1'b1, 1'b0);
        end else begin
            exp = sbq.pop_front();
            check("result", {res_timeout, res_nonce, res_hash}, exp);
        end
        if (try_byte) begin
            in_valid = 1'b1;
            in_byte  = 8'hEE;
        end
        tick();
        res_ready = 1'b0;
        check("res_valid_clear", res_valid, 1'b0);
        check("in_ready_after", in_ready, 1'b1);
        if (try_byte) begin
            check("b2b_not_taken", payload[95:88], old_b0);
            in_valid = 1'b0;
        end
    endtask

    logic [7:0] job1[13] = '{8'h39, 8'h7d, 8'h9f, 8'h2f, 8'h40, 8'hca, 8'h9e,
                             8'h6c, 8'h6b, 8'h1f, 8'h33, 8'h24, 8'h0a};
    logic [7:0] job2[13] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd,
                             8'hef, 8'hfe, 8'hdc, 8'hba, 8'h98, 8'h7f};
    logic [7:0] job3[13];

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        terminado = 1'b0;
        nonceIn   = '0;
        hashIn    = '0;
        res_ready = 1'b0;
        for (int k = 0; k < 13; k++) job3[k] = 8'($urandom);

        // Reset held for three cycles
        for (int c = 0; c < 3; c++) tick();
        check("rst_outputs", {payload, target, active, res_valid, res_nonce, res_hash, res_timeout, busy},
              '0);
        check("rst_in_ready", in_ready, 1'b0);
        reset_n = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1'b1);

        // terminado is ignored while collecting
        terminado = 1'b1;
        tick();
        terminado = 1'b0;
        check("idle_term_busy", busy, 1'b0);
        check("idle_term_valid", res_valid, 1'b0);

        // Job 1, contiguous bytes
        send_job(job1, 0);
        check("j1_payload", payload, 96'h397d9f2f40ca9e6c6b1f3324);
        check("j1_target", target, 8'h0a);
        check("j1_active", active, 1'b1);
        check("j1_busy", busy, 1'b1);
        check("j1_in_ready", in_ready, 1'b0);
        tick();
        finish_job(32'h0000_0123, 24'h05abcd);
        consume(4, 1'b1, 8'h39);

        // Job 2 with gaps, then stray bytes during RUN
        send_job(job2, 2);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_byte  = 8'h55;
            tick();
        end
        in_valid = 1'b0;
        check("j2_payload", payload, pack(job2));
        check("j2_target", target, 8'h7f);
        check("j2_run_in_ready", in_ready, 1'b0);
        check("j2_active", active, 1'b1);
        finish_job(32'hdead_beef, 24'h123456);
        consume(0, 1'b0, 8'h00);
        check("j2_keep_payload", payload, pack(job2));

        // Reset during RUN aborts the job
        send_job(job3, 1);
        check("j3_payload", payload, pack(job3));
        tick();
        reset_n   = 1'b0;
        terminado = 1'b1;
        tick();
        terminado = 1'b0;
        check("mid_rst_active", active, 1'b0);
        check("mid_rst_valid", res_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_payload", payload, '0);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check("post_rst_valid", res_valid, 1'b0);
        check("post_rst_in_ready", in_ready, 1'b1);
        send_job(job1, 0);
        check("reload_payload", payload, pack(job1));
        check("reload_target", target, 8'h0a);
        finish_job(32'h8000_0001, 24'hffffff);
        consume(1, 1'b0, 8'h00);

        // Watchdog: terminado never arrives
        send_job(job2, 0);
`ifdef DESPACHO_TIMEOUT_EN
        sbq.push_back({1'b1, 32'hffff_ffff, 24'h000000});
        for (int c = 1; c <= TCYC; c++) begin
            tick();
            if (c == TCYC - 1) check("tmo_early", res_valid, 1'b0);
        end
        check("tmo_valid", res_valid, 1'b1);
        check("tmo_active", active, 1'b0);
        consume(0, 1'b0, 8'h00);
`else
        for (int c = 1; c <= TCYC + 50; c++) tick();
        check("no_tmo_valid", res_valid, 1'b0);
        check("no_tmo_active", active, 1'b1);
        finish_job(32'h0000_0042, 24'h000777);
        consume(0, 1'b0, 8'h00);
`endif

        check("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
